// File: rtl/rs_pool_if.sv
// ----------------------------------------------------------------------------
// rs_pool_if
// Bundles every reservation-station signal except the clock and reset.
// This covers the control inputs, the allocator port, the CDB snoop port,
// the execution-unit handshake and the dispatch outputs.
//
// Signals (direction seen from the station, i.e. the slave modport):
//   rdy          in   global ready; low freezes all station state
//   flush        in   mispredict squash; empties the station
//   alloc_en     in   write a new op this cycle
//   alloc_op     in   op code
//   alloc_pc     in   op pc
//   alloc_tagx   in   source x tag (0 = data valid)
//   alloc_tagy   in   source y tag (0 = data valid)
//   alloc_datax  in   source x data when tag 0
//   alloc_datay  in   source y data when tag 0
//   alloc_tagw   in   destination tag
//   alloc_addrw  in   destination register
//   cdb_en       in   per-port broadcast valid
//   cdb_tag      in   packed tags, port i at [i*TAG_W +: TAG_W]
//   cdb_data     in   packed results, port i at [i*DATA_W +: DATA_W]
//   ex_ready     in   execution unit accepts a dispatch this cycle
//   full         out  occupancy equals DEPTH
//   count        out  registered occupancy
//   disp_valid   out  one-cycle pulse per dispatch
//   disp_op, disp_pc, disp_datax, disp_datay, disp_tagw, disp_addrw
//                out  dispatched fields, held between pulses
// ----------------------------------------------------------------------------
interface rs_pool_if #(
    parameter int NUM_CDB = 4,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 6,
    parameter int RA_W    = 5,
    parameter int CNT_W   = 3
);
    logic                      rdy;
    logic                      flush;
    logic                      alloc_en;
    logic [OP_W-1:0]           alloc_op;
    logic [31:0]               alloc_pc;
    logic [TAG_W-1:0]          alloc_tagx;
    logic [TAG_W-1:0]          alloc_tagy;
    logic [DATA_W-1:0]         alloc_datax;
    logic [DATA_W-1:0]         alloc_datay;
    logic [TAG_W-1:0]          alloc_tagw;
    logic [RA_W-1:0]           alloc_addrw;
    logic [NUM_CDB-1:0]        cdb_en;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] cdb_data;
    logic                      ex_ready;
    logic                      full;
    logic [CNT_W-1:0]          count;
    logic                      disp_valid;
    logic [OP_W-1:0]           disp_op;
    logic [31:0]               disp_pc;
    logic [DATA_W-1:0]         disp_datax;
    logic [DATA_W-1:0]         disp_datay;
    logic [TAG_W-1:0]          disp_tagw;
    logic [RA_W-1:0]           disp_addrw;

    // Allocator / CDB / execution-unit side.
    modport master (
        output rdy, flush, alloc_en, alloc_op, alloc_pc, alloc_tagx, alloc_tagy,
               alloc_datax, alloc_datay, alloc_tagw, alloc_addrw,
               cdb_en, cdb_tag, cdb_data, ex_ready,
        input  full, count, disp_valid, disp_op, disp_pc, disp_datax, disp_datay,
               disp_tagw, disp_addrw
    );

    // Reservation station side.
    modport slave (
        input  rdy, flush, alloc_en, alloc_op, alloc_pc, alloc_tagx, alloc_tagy,
               alloc_datax, alloc_datay, alloc_tagw, alloc_addrw,
               cdb_en, cdb_tag, cdb_data, ex_ready,
        output full, count, disp_valid, disp_op, disp_pc, disp_datax, disp_datay,
               disp_tagw, disp_addrw
    );
endinterface

// File: rtl/rs_pool.sv
// ----------------------------------------------------------------------------
// rs_pool
// Parametrised reservation station. It holds up to DEPTH renamed ops in a
// compacting queue, with slot 0 the oldest. Each cycle it snoops NUM_CDB
// result buses to wake waiting operands. It dispatches the oldest ready op
// to a single execution unit whenever that unit is ready.
//
// Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   bus   rs_pool_if.slave  control, alloc, CDB, ex handshake and dispatch
//         (see rs_pool_if.sv for the individual signals)
//
// Optional feature, macro RS_SAME_CYCLE_WAKE_EN:
//   defined   - operands matched on the CDB this cycle already count as
//               ready, and the CDB data is forwarded straight into
//               disp_datax/y.
//   undefined - an entry woken in cycle N is first selectable in cycle N+1.
// ----------------------------------------------------------------------------
module rs_pool #(
    parameter int DEPTH   = 4,
    parameter int NUM_CDB = 4,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 6,
    parameter int RA_W    = 5
) (
    input logic   clk,
    input logic   rst,
    rs_pool_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    // Registered entry state; only slots below count_q are meaningful.
    logic [OP_W-1:0]   op_q    [DEPTH];
    logic [31:0]       pc_q    [DEPTH];
    logic [TAG_W-1:0]  tagx_q  [DEPTH];
    logic [TAG_W-1:0]  tagy_q  [DEPTH];
    logic [DATA_W-1:0] datax_q [DEPTH];
    logic [DATA_W-1:0] datay_q [DEPTH];
    logic [TAG_W-1:0]  tagw_q  [DEPTH];
    logic [RA_W-1:0]   addrw_q [DEPTH];
    logic [CNT_W-1:0]  count_q;

    // Entry operands after this cycle's CDB snoop.
    logic [TAG_W-1:0]  wtagx  [DEPTH];
    logic [TAG_W-1:0]  wtagy  [DEPTH];
    logic [DATA_W-1:0] wdatax [DEPTH];
    logic [DATA_W-1:0] wdatay [DEPTH];

    // Allocator operands after the same-cycle CDB bypass.
    logic [TAG_W-1:0]  atagx, atagy;
    logic [DATA_W-1:0] adatax, adatay;

    logic [DEPTH-1:0]  ready;
    logic              found;
    logic [IDX_W-1:0]  sel;
    logic              full;
    logic              do_disp;
    logic              do_alloc;
    logic [CNT_W-1:0]  alloc_slot;
    logic [CNT_W-1:0]  count_n;

    // Next-state entry arrays after compaction and allocation.
    logic [OP_W-1:0]   op_n    [DEPTH];
    logic [31:0]       pc_n    [DEPTH];
    logic [TAG_W-1:0]  tagx_n  [DEPTH];
    logic [TAG_W-1:0]  tagy_n  [DEPTH];
    logic [DATA_W-1:0] datax_n [DEPTH];
    logic [DATA_W-1:0] datay_n [DEPTH];
    logic [TAG_W-1:0]  tagw_n  [DEPTH];
    logic [RA_W-1:0]   addrw_n [DEPTH];

    // Dispatch output registers.
    logic              disp_valid_q;
    logic [OP_W-1:0]   disp_op_q;
    logic [31:0]       disp_pc_q;
    logic [DATA_W-1:0] disp_datax_q;
    logic [DATA_W-1:0] disp_datay_q;
    logic [TAG_W-1:0]  disp_tagw_q;
    logic [RA_W-1:0]   disp_addrw_q;

    // Returns {tag, data} after comparing one operand against every CDB
    // port. Ports are scanned from high to low, so the lowest matching
    // port has the final say. Tag 0 never matches because it already
    // means "data valid".
    function automatic logic [TAG_W+DATA_W-1:0] snoop(
        input logic [TAG_W-1:0]          tag,
        input logic [DATA_W-1:0]         data,
        input logic [NUM_CDB-1:0]        en,
        input logic [NUM_CDB*TAG_W-1:0]  ctag,
        input logic [NUM_CDB*DATA_W-1:0] cdata
    );
        logic [TAG_W-1:0]  t;
        logic [DATA_W-1:0] d;
        t = tag;
        d = data;
        for (int i = NUM_CDB - 1; i >= 0; i--) begin
            if (en[i] && (tag != '0) && (ctag[i*TAG_W +: TAG_W] == tag)) begin
                t = '0;
                d = cdata[i*DATA_W +: DATA_W];
            end
        end
        return {t, d};
    endfunction

    // Wakeup and select. The snooped operands feed the next-state arrays
    // in both build modes. The ready vector looks at the snooped tags only
    // when same-cycle wake is built in. Otherwise it uses the registered
    // tags, so a freshly woken entry waits one cycle before it can be
    // selected.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            {wtagx[j], wdatax[j]} = snoop(tagx_q[j], datax_q[j], bus.cdb_en, bus.cdb_tag, bus.cdb_data);
            {wtagy[j], wdatay[j]} = snoop(tagy_q[j], datay_q[j], bus.cdb_en, bus.cdb_tag, bus.cdb_data);
        end
        {atagx, adatax} = snoop(bus.alloc_tagx, bus.alloc_datax, bus.cdb_en, bus.cdb_tag, bus.cdb_data);
        {atagy, adatay} = snoop(bus.alloc_tagy, bus.alloc_datay, bus.cdb_en, bus.cdb_tag, bus.cdb_data);

        ready = '0;
        for (int j = 0; j < DEPTH; j++) begin
`ifdef RS_SAME_CYCLE_WAKE_EN
            ready[j] = (CNT_W'(j) < count_q) && (wtagx[j] == '0) && (wtagy[j] == '0);
`else
            ready[j] = (CNT_W'(j) < count_q) && (tagx_q[j] == '0) && (tagy_q[j] == '0);
`endif
        end

        // Scanning downward leaves the lowest (oldest) ready slot selected.
        found = 1'b0;
        sel   = '0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (ready[j]) begin
                found = 1'b1;
                sel   = IDX_W'(j);
            end
        end

        full       = (count_q == CNT_W'(DEPTH));
        do_disp    = bus.ex_ready && found;
        // The full check uses the registered count, so a dispatch in the
        // same cycle never makes room for an allocation.
        do_alloc   = bus.alloc_en && !full;
        alloc_slot = count_q - CNT_W'(do_disp);
        count_n    = count_q + CNT_W'(do_alloc) - CNT_W'(do_disp);
    end

    // Compaction and allocation. Every slot first keeps its own woken
    // contents. Slots at or above the dispatched one then pull from the
    // slot above. Finally, the new op lands just past the surviving entries.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            op_n[j]    = op_q[j];
            pc_n[j]    = pc_q[j];
            tagx_n[j]  = wtagx[j];
            tagy_n[j]  = wtagy[j];
            datax_n[j] = wdatax[j];
            datay_n[j] = wdatay[j];
            tagw_n[j]  = tagw_q[j];
            addrw_n[j] = addrw_q[j];
        end
        for (int j = 0; j < DEPTH - 1; j++) begin
            if (do_disp && (IDX_W'(j) >= sel)) begin
                op_n[j]    = op_q[j+1];
                pc_n[j]    = pc_q[j+1];
                tagx_n[j]  = wtagx[j+1];
                tagy_n[j]  = wtagy[j+1];
                datax_n[j] = wdatax[j+1];
                datay_n[j] = wdatay[j+1];
                tagw_n[j]  = tagw_q[j+1];
                addrw_n[j] = addrw_q[j+1];
            end
        end
        for (int j = 0; j < DEPTH; j++) begin
            if (do_alloc && (CNT_W'(j) == alloc_slot)) begin
                op_n[j]    = bus.alloc_op;
                pc_n[j]    = bus.alloc_pc;
                tagx_n[j]  = atagx;
                tagy_n[j]  = atagy;
                datax_n[j] = adatax;
                datay_n[j] = adatay;
                tagw_n[j]  = bus.alloc_tagw;
                addrw_n[j] = bus.alloc_addrw;
            end
        end
    end

    // State update. Reset beats everything. rdy low freezes the station
    // completely. Flush empties it and drops any dispatch, but it leaves
    // the last dispatched fields on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            disp_valid_q <= 1'b0;
            disp_op_q    <= '0;
            disp_pc_q    <= '0;
            disp_datax_q <= '0;
            disp_datay_q <= '0;
            disp_tagw_q  <= '0;
            disp_addrw_q <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                op_q[j]    <= '0;
                pc_q[j]    <= '0;
                tagx_q[j]  <= '0;
                tagy_q[j]  <= '0;
                datax_q[j] <= '0;
                datay_q[j] <= '0;
                tagw_q[j]  <= '0;
                addrw_q[j] <= '0;
            end
        end else if (bus.rdy) begin
            if (bus.flush) begin
                count_q      <= '0;
                disp_valid_q <= 1'b0;
            end else begin
                count_q      <= count_n;
                disp_valid_q <= do_disp;
                for (int j = 0; j < DEPTH; j++) begin
                    op_q[j]    <= op_n[j];
                    pc_q[j]    <= pc_n[j];
                    tagx_q[j]  <= tagx_n[j];
                    tagy_q[j]  <= tagy_n[j];
                    datax_q[j] <= datax_n[j];
                    datay_q[j] <= datay_n[j];
                    tagw_q[j]  <= tagw_n[j];
                    addrw_q[j] <= addrw_n[j];
                end
                if (do_disp) begin
                    disp_op_q    <= op_q[sel];
                    disp_pc_q    <= pc_q[sel];
                    disp_datax_q <= wdatax[sel];
                    disp_datay_q <= wdatay[sel];
                    disp_tagw_q  <= tagw_q[sel];
                    disp_addrw_q <= addrw_q[sel];
                end
            end
        end
    end

    assign bus.full       = full;
    assign bus.count      = count_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.disp_op    = disp_op_q;
    assign bus.disp_pc    = disp_pc_q;
    assign bus.disp_datax = disp_datax_q;
    assign bus.disp_datay = disp_datay_q;
    assign bus.disp_tagw  = disp_tagw_q;
    assign bus.disp_addrw = disp_addrw_q;
endmodule

// File: tb/tb_rs_pool.sv
// ----------------------------------------------------------------------------
// tb_rs_pool
// Self-checking bench for rs_pool with the default parameters
// (DEPTH=4, NUM_CDB=4). Every op that is expected to dispatch is pushed to
// a scoreboard queue when it is allocated. A negedge monitor pops one entry
// per disp_valid pulse and compares all dispatched fields against it.
// Expected latencies follow RS_SAME_CYCLE_WAKE_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_rs_pool;
    localparam int DEPTH   = 4;
    localparam int NUM_CDB = 4;
    localparam int TAG_W   = 5;
    localparam int DATA_W  = 32;
    localparam int OP_W    = 6;
    localparam int RA_W    = 5;
    localparam int CNT_W   = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rs_pool_if #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .DATA_W(DATA_W),
                 .OP_W(OP_W), .RA_W(RA_W), .CNT_W(CNT_W)) bus ();

    rs_pool #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .DATA_W(DATA_W),
              .OP_W(OP_W), .RA_W(RA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [31:0]       pc;
        logic [DATA_W-1:0] datax;
        logic [DATA_W-1:0] datay;
        logic [TAG_W-1:0]  tagw;
        logic [RA_W-1:0]   addrw;
    } disp_t;

    typedef struct {
        logic [OP_W-1:0]           op;
        logic [31:0]               pc;
        logic [TAG_W-1:0]          tagx;
        logic [DATA_W-1:0]         datax;
        logic [TAG_W-1:0]          tagy;
        logic [DATA_W-1:0]         datay;
        logic [NUM_CDB-1:0]        cdb_en;
        logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
        logic [NUM_CDB*DATA_W-1:0] cdb_data;
        logic [DATA_W-1:0]         exp_datax;
        logic [DATA_W-1:0]         exp_datay;
    } vec_t;

    disp_t pending[$];
    disp_t exp_d;
    vec_t  vecs[5];
    int    total = 0;
    int    bad   = 0;

`ifdef RS_SAME_CYCLE_WAKE_EN
    localparam bit SAME_WAKE = 1'b1;
`else
    localparam bit SAME_WAKE = 1'b0;
`endif

    // Compares one value and counts it; prints a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: each dispatch pulse must match the oldest
    // pending expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.disp_valid === 1'b1) begin
            if (pending.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_dispatch: got pc 0x%0h, expected no dispatch", bus.disp_pc);
            end else begin
                exp_d = pending.pop_front();
                checkOutput("disp_op",    64'(bus.disp_op),    64'(exp_d.op));
                checkOutput("disp_pc",    64'(bus.disp_pc),    64'(exp_d.pc));
                checkOutput("disp_datax", 64'(bus.disp_datax), 64'(exp_d.datax));
                checkOutput("disp_datay", 64'(bus.disp_datay), 64'(exp_d.datay));
                checkOutput("disp_tagw",  64'(bus.disp_tagw),  64'(exp_d.tagw));
                checkOutput("disp_addrw", 64'(bus.disp_addrw), 64'(exp_d.addrw));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rdy      = 1'b1;
        bus.flush    = 1'b0;
        bus.alloc_en = 1'b0;
        bus.cdb_en   = '0;
        bus.cdb_tag  = '0;
        bus.cdb_data = '0;
    endtask

    task automatic applyStimulus(
        input logic [OP_W-1:0] op, input logic [31:0] pc,
        input logic [TAG_W-1:0] tx, input logic [DATA_W-1:0] dx,
        input logic [TAG_W-1:0] ty, input logic [DATA_W-1:0] dy,
        input logic [TAG_W-1:0] tw, input logic [RA_W-1:0] aw
    );
        bus.alloc_en    = 1'b1;
        bus.alloc_op    = op;
        bus.alloc_pc    = pc;
        bus.alloc_tagx  = tx;
        bus.alloc_datax = dx;
        bus.alloc_tagy  = ty;
        bus.alloc_datay = dy;
        bus.alloc_tagw  = tw;
        bus.alloc_addrw = aw;
    endtask

    task automatic drive_cdb(input int port, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        bus.cdb_en[port]                   = 1'b1;
        bus.cdb_tag[port*TAG_W +: TAG_W]   = tag;
        bus.cdb_data[port*DATA_W +: DATA_W] = data;
    endtask

    task automatic expect_disp(
        input logic [OP_W-1:0] op, input logic [31:0] pc,
        input logic [DATA_W-1:0] dx, input logic [DATA_W-1:0] dy,
        input logic [TAG_W-1:0] tw, input logic [RA_W-1:0] aw
    );
        disp_t d;
        d.op = op; d.pc = pc; d.datax = dx; d.datay = dy; d.tagw = tw; d.addrw = aw;
        pending.push_back(d);
    endtask

    initial begin
        // Single-op vectors: ready operands or operands woken by the alloc bypass.
        vecs[0] = '{6'd1, 32'h100, 5'd0, 32'd5,  5'd0, 32'd7,  4'b0000,
                    {5'd0, 5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h0, 32'h0}, 32'd5,  32'd7};
        vecs[1] = '{6'd2, 32'h104, 5'd4, 32'd0,  5'd0, 32'd9,  4'b0010,
                    {5'd0, 5'd0, 5'd4, 5'd0}, {32'h0, 32'h0, 32'h44, 32'h0}, 32'h44, 32'd9};
        vecs[2] = '{6'd3, 32'h108, 5'd6, 32'd0,  5'd6, 32'd0,  4'b1000,
                    {5'd6, 5'd0, 5'd0, 5'd0}, {32'h66, 32'h0, 32'h0, 32'h0}, 32'h66, 32'h66};
        vecs[3] = '{6'd4, 32'h10C, 5'd7, 32'd0,  5'd8, 32'd0,  4'b0101,
                    {5'd0, 5'd7, 5'd0, 5'd8}, {32'h0, 32'h70, 32'h0, 32'h80}, 32'h70, 32'h80};
        vecs[4] = '{6'd5, 32'h110, 5'd5, 32'd0,  5'd0, 32'hFF, 4'b1010,
                    {5'd5, 5'd0, 5'd5, 5'd0}, {32'h33, 32'h0, 32'h11, 32'h0}, 32'h11, 32'hFF};

        // Reset state.
        rst = 1'b1;
        idle();
        bus.ex_ready = 1'b0;
        applyStimulus('0, '0, '0, '0, '0, '0, '0, '0);
        bus.alloc_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_count",      64'(bus.count),      64'd0);
        checkOutput("reset_full",       64'(bus.full),       64'd0);
        checkOutput("reset_disp_valid", 64'(bus.disp_valid), 64'd0);
        checkOutput("reset_disp_pc",    64'(bus.disp_pc),    64'd0);
        checkOutput("reset_disp_datax", 64'(bus.disp_datax), 64'd0);

        // Table-driven single-op latency and bypass checks.
        bus.ex_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].op, vecs[v].pc, vecs[v].tagx, vecs[v].datax,
                          vecs[v].tagy, vecs[v].datay, TAG_W'(v + 1), RA_W'(v + 10));
            bus.cdb_en   = vecs[v].cdb_en;
            bus.cdb_tag  = vecs[v].cdb_tag;
            bus.cdb_data = vecs[v].cdb_data;
            expect_disp(vecs[v].op, vecs[v].pc, vecs[v].exp_datax, vecs[v].exp_datay,
                        TAG_W'(v + 1), RA_W'(v + 10));
            tick();
            idle();
            checkOutput("vec_count_after_alloc", 64'(bus.count),      64'd1);
            checkOutput("vec_no_early_disp",     64'(bus.disp_valid), 64'd0);
            tick();
            checkOutput("vec_count_after_disp",  64'(bus.count),      64'd0);
            checkOutput("vec_disp_pulse",        64'(bus.disp_valid), 64'd1);
            tick();
            checkOutput("vec_pulse_ends",        64'(bus.disp_valid), 64'd0);
            checkOutput("vec_datax_held",        64'(bus.disp_datax), 64'(vecs[v].exp_datax));
        end

        // CDB wake two cycles after alloc (port 2).
        applyStimulus(6'd7, 32'h180, 5'd3, 32'd0, 5'd0, 32'd1, 5'd20, 5'd2);
        expect_disp(6'd7, 32'h180, 32'hAB, 32'd1, 5'd20, 5'd2);
        tick();
        idle();
        tick();
        drive_cdb(2, 5'd3, 32'hAB);
        tick();
        idle();
        checkOutput("wake_disp_at_wake_edge", 64'(bus.disp_valid), 64'(SAME_WAKE));
        checkOutput("wake_count",             64'(bus.count),      SAME_WAKE ? 64'd0 : 64'd1);
        tick();
        checkOutput("wake_disp_next_edge",    64'(bus.disp_valid), 64'(!SAME_WAKE));
        tick();
        checkOutput("wake_pending_empty",     64'(pending.size()), 64'd0);

        // Fill to DEPTH, overflow alloc dropped, then in-order drain.
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(OP_W'(10 + k), 32'(4 * k), 5'd9, 32'd0, 5'd0, 32'(k), TAG_W'(k), RA_W'(k));
            tick();
        end
        idle();
        checkOutput("fill_full",  64'(bus.full),  64'd1);
        checkOutput("fill_count", 64'(bus.count), 64'd4);
        applyStimulus(6'd30, 32'h10, 5'd9, 32'd0, 5'd0, 32'd0, 5'd30, 5'd30);
        tick();
        idle();
        checkOutput("overflow_count", 64'(bus.count), 64'd4);
        for (int k = 0; k < DEPTH; k++)
            expect_disp(OP_W'(10 + k), 32'(4 * k), 32'h99, 32'(k), TAG_W'(k), RA_W'(k));
        drive_cdb(0, 5'd9, 32'h99);
        tick();
        idle();
        for (int k = 0; k < 5; k++) tick();
        checkOutput("drain_count",         64'(bus.count),      64'd0);
        checkOutput("drain_full",          64'(bus.full),       64'd0);
        checkOutput("drain_pending_empty", 64'(pending.size()), 64'd0);

        // Dispatch of slot 2 with a same-cycle alloc; compaction order.
        bus.ex_ready = 1'b0;
        applyStimulus(6'd40, 32'h200, 5'd10, 32'd0, 5'd0, 32'd1, 5'd1, 5'd1);
        tick();
        applyStimulus(6'd41, 32'h204, 5'd11, 32'd0, 5'd0, 32'd2, 5'd2, 5'd2);
        tick();
        applyStimulus(6'd42, 32'h208, 5'd0, 32'd3, 5'd0, 32'd4, 5'd3, 5'd3);
        tick();
        idle();
        checkOutput("slot2_setup_count", 64'(bus.count), 64'd3);
        bus.ex_ready = 1'b1;
        expect_disp(6'd42, 32'h208, 32'd3, 32'd4, 5'd3, 5'd3);
        applyStimulus(6'd43, 32'h20C, 5'd12, 32'd0, 5'd0, 32'd5, 5'd4, 5'd4);
        tick();
        idle();
        checkOutput("alloc_disp_count", 64'(bus.count),      64'd3);
        checkOutput("alloc_disp_valid", 64'(bus.disp_valid), 64'd1);
        expect_disp(6'd40, 32'h200, 32'hA0, 32'd1, 5'd1, 5'd1);
        expect_disp(6'd41, 32'h204, 32'hB0, 32'd2, 5'd2, 5'd2);
        expect_disp(6'd43, 32'h20C, 32'hD0, 32'd5, 5'd4, 5'd4);
        drive_cdb(0, 5'd10, 32'hA0);
        drive_cdb(1, 5'd11, 32'hB0);
        drive_cdb(2, 5'd12, 32'hD0);
        tick();
        idle();
        for (int k = 0; k < 5; k++) tick();
        checkOutput("compact_count",         64'(bus.count),      64'd0);
        checkOutput("compact_pending_empty", 64'(pending.size()), 64'd0);

        // Flush beats a same-cycle alloc and dispatch.
        bus.ex_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(OP_W'(50 + k), 32'(32'h400 + 4 * k), 5'd0, 32'd1, 5'd0, 32'd2, 5'd5, 5'd5);
            tick();
        end
        idle();
        checkOutput("flush_setup_count", 64'(bus.count), 64'd3);
        bus.flush    = 1'b1;
        bus.ex_ready = 1'b1;
        applyStimulus(6'd55, 32'h40C, 5'd0, 32'd1, 5'd0, 32'd2, 5'd6, 5'd6);
        tick();
        idle();
        checkOutput("flush_count",      64'(bus.count),      64'd0);
        checkOutput("flush_disp_valid", 64'(bus.disp_valid), 64'd0);
        for (int k = 0; k < 3; k++) tick();
        checkOutput("flush_stays_empty", 64'(bus.count), 64'd0);

        // rdy low during the awaited broadcast: the entry keeps waiting.
        applyStimulus(6'd60, 32'h300, 5'd13, 32'd0, 5'd0, 32'd6, 5'd7, 5'd7);
        tick();
        idle();
        bus.rdy = 1'b0;
        drive_cdb(0, 5'd13, 32'h13);
        tick();
        idle();
        checkOutput("rdy_low_disp_valid", 64'(bus.disp_valid), 64'd0);
        tick();
        tick();
        checkOutput("rdy_low_still_waiting", 64'(bus.count),      64'd1);
        checkOutput("rdy_low_no_disp",       64'(bus.disp_valid), 64'd0);
        expect_disp(6'd60, 32'h300, 32'h13, 32'd6, 5'd7, 5'd7);
        drive_cdb(0, 5'd13, 32'h13);
        tick();
        idle();
        tick();
        tick();
        checkOutput("rdy_wake_count",         64'(bus.count),      64'd0);
        checkOutput("rdy_wake_pending_empty", 64'(pending.size()), 64'd0);

        // Reset mid-operation overrides rdy low.
        applyStimulus(6'd61, 32'h500, 5'd20, 32'd0, 5'd0, 32'd0, 5'd8, 5'd8);
        tick();
        tick();
        idle();
        checkOutput("midrst_setup_count", 64'(bus.count), 64'd2);
        rst     = 1'b1;
        bus.rdy = 1'b0;
        tick();
        rst = 1'b0;
        idle();
        checkOutput("midrst_count", 64'(bus.count), 64'd0);
        drive_cdb(0, 5'd20, 32'h20);
        tick();
        idle();
        tick();
        tick();
        checkOutput("midrst_no_revival", 64'(bus.count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
